mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arb_pkg.sv | 22 ++
 rtl/mem_arb_rr.sv | 35 +++
 rtl/mem_arbiter.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the I/D cache memory arbiter.
package mem_arb_pkg;

   localparam int unsigned BeatsDefault = 4;

   typedef enum logic [1:0] {
      StIdle,
      StBurst,
      StDone
   } state_e;

   typedef enum logic {
      OwnI,
      OwnD
   } owner_e;

   typedef enum logic {
      DirRd,
      DirWr
   } dir_e;

endpackage

// File: rtl/mem_arb_rr.sv
// Two-input round-robin picker; remembers which side was granted last.
module mem_arb_rr
   import mem_arb_pkg::*;
(
   input  logic clk_i,
   input  logic rst_ni,
   input  logic i_req_i,
   input  logic d_req_i,
   input  logic update_i,
   output logic valid_o,
   output logic pick_d_o
);

   owner_e last_q, last_d;

   assign valid_o  = i_req_i | d_req_i;
   // On a tie the side that did not win last time gets the grant.
   assign pick_d_o = d_req_i & (~i_req_i | (last_q == OwnI));

   always_comb begin
      last_d = last_q;
      if (update_i && valid_o) begin
         last_d = pick_d_o ? OwnD : OwnI;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         last_q <= OwnI;
      end else begin
         last_q <= last_d;
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates I-cache refills and D-cache refills/writebacks onto one memory port,
// moving one cache block per grant as a fixed-length burst.
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int unsigned BEATS = BeatsDefault,
   parameter int unsigned AW    = 32,
   parameter int unsigned DW    = 32
) (
   input  logic          CLK,
   input  logic          RST,
   input  logic          i_req,
   input  logic [AW-1:0] i_addr,
   input  logic          d_req,
   input  logic          d_we,
   input  logic [AW-1:0] d_addr,
   input  logic [DW-1:0] d_wdata,
   output logic          i_done,
   output logic          d_done,
   output logic          i_rvalid,
   output logic          d_rvalid,
   output logic [DW-1:0] rdata,
   output logic [1:0]    rbeat,
   output logic [1:0]    d_wbeat,
   output logic          mem_re,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata
);

   localparam logic [1:0] LastBeat = 2'(BEATS - 1);

   state_e        state_q, state_d;
   owner_e        owner_q, owner_d;
   dir_e          dir_q, dir_d;
   logic [AW-5:0] addr_q, addr_d;
   logic [1:0]    beat_q, beat_d;
   logic          rvalid_q, rvalid_d;
   logic [1:0]    rbeat_q, rbeat_d;

   logic grant_en;
   logic grant_valid;
   logic grant_pick_d;
   logic in_burst;
   logic wr_burst;

   // Block offset comes from the beat counter, so request bits [3:0] are dropped.
   logic unused_addr_lsbs;
   assign unused_addr_lsbs = ^{i_addr[3:0], d_addr[3:0]};

   mem_arb_rr u_rr (
      .clk_i    (CLK),
      .rst_ni   (RST),
      .i_req_i  (i_req),
      .d_req_i  (d_req),
      .update_i (grant_en),
      .valid_o  (grant_valid),
      .pick_d_o (grant_pick_d)
   );

   always_comb begin
      state_d  = state_q;
      owner_d  = owner_q;
      dir_d    = dir_q;
      addr_d   = addr_q;
      beat_d   = beat_q;
      grant_en = 1'b0;
      unique case (state_q)
         StIdle: begin
            beat_d   = '0;
            grant_en = 1'b1;
            if (grant_valid) begin
               state_d = StBurst;
               if (grant_pick_d) begin
                  owner_d = OwnD;
                  dir_d   = d_we ? DirWr : DirRd;
                  addr_d  = d_addr[AW-1:4];
               end else begin
                  owner_d = OwnI;
                  dir_d   = DirRd;
                  addr_d  = i_addr[AW-1:4];
               end
            end
         end
         StBurst: begin
            if (beat_q == LastBeat) begin
               beat_d  = '0;
               state_d = StDone;
            end else begin
               beat_d = beat_q + 2'd1;
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // Memory answers one cycle after mem_re, so the read return trails the beat by one.
   assign rvalid_d = (state_q == StBurst) && (dir_q == DirRd);
   assign rbeat_d  = beat_q;

   always_ff @(posedge CLK) begin
      if (!RST) begin
         state_q  <= StIdle;
         owner_q  <= OwnI;
         dir_q    <= DirRd;
         addr_q   <= '0;
         beat_q   <= '0;
         rvalid_q <= 1'b0;
         rbeat_q  <= '0;
      end else begin
         state_q  <= state_d;
         owner_q  <= owner_d;
         dir_q    <= dir_d;
         addr_q   <= addr_d;
         beat_q   <= beat_d;
         rvalid_q <= rvalid_d;
         rbeat_q  <= rbeat_d;
      end
   end

   assign in_burst  = state_q == StBurst;
   assign wr_burst  = in_burst && (dir_q == DirWr) && (owner_q == OwnD);

   assign mem_re    = in_burst && (dir_q == DirRd);
   assign mem_we    = wr_burst;
   assign mem_addr  = in_burst ? {addr_q, beat_q, 2'b00} : '0;
   assign mem_wdata = wr_burst ? d_wdata : '0;
   assign d_wbeat   = wr_burst ? beat_q : '0;

   assign i_rvalid  = rvalid_q && (owner_q == OwnI);
   assign d_rvalid  = rvalid_q && (owner_q == OwnD);
   assign rdata     = rvalid_q ? mem_rdata : '0;
   assign rbeat     = rvalid_q ? rbeat_q : '0;

   assign i_done    = (state_q == StDone) && (owner_q == OwnI);
   assign d_done    = (state_q == StDone) && (owner_q == OwnD);

endmodule
